// File: rtl/matrix_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_loader                                                            |
// | Pulls two matrices and a config word from memory, drives an external     |
// | multiplier and writes the packed product back to memory.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matrix_loader #(
  parameter int R1     = 2,
  parameter int C1     = 2,
  parameter int C2     = 2,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  input  logic [31:0]               mem_rdata,
  output logic                      mem_wr,
  output logic [31:0]               mem_wdata,
  output logic                      mm_rst_n,
  output logic                      mm_start,
  output logic                      mm_show,
  input  logic                      mm_finish,
  output logic [R1*C1*WIDTH-1:0]    mm_mat1,
  output logic [C1*C2*WIDTH-1:0]    mm_mat2,
  input  logic [R1*C2*WIDTH-1:0]    mm_result
);

  localparam int c_m1  = R1 * C1;
  localparam int c_m2  = C1 * C2;
  localparam int c_m3  = R1 * C2;
  localparam int c_nrd = c_m1 + c_m2;

  localparam logic [31:0]       c_cfg      = {8'(C2), 8'(C1), 8'(C1), 8'(R1)};
  localparam logic [ADDR_W-1:0] c_rd_last  = ADDR_W'(c_nrd);
  localparam logic [ADDR_W-1:0] c_res_base = ADDR_W'(c_nrd + 2);
  localparam logic [ADDR_W-1:0] c_wr_last  = ADDR_W'(c_m3 - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RD_CFG   = 4'd1,
    S_CHK      = 4'd2,
    S_RD_MAT   = 4'd3,
    S_CLR      = 4'd4,
    S_START    = 4'd5,
    S_WAIT_FIN = 4'd6,
    S_SHOW     = 4'd7,
    S_WR_RES   = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_idx;
  logic [c_nrd*WIDTH-1:0]  r_mats;
  logic [c_m3*WIDTH-1:0]   r_result;
  logic                    r_mm_rst_n;
  logic [WIDTH-1:0]        w_rd_word;
  logic [31:0]             w_res_top;

  assign w_rd_word = WIDTH'(mem_rdata);
  assign w_res_top = 32'(r_result[c_m3*WIDTH-1 -: WIDTH]);

  // Both matrices live in one shift register: the first word read ends up
  // in the most-significant slice, which is element 0 of matrix 1.
  assign mm_mat1  = r_mats[c_nrd*WIDTH-1 -: c_m1*WIDTH];
  assign mm_mat2  = r_mats[c_m2*WIDTH-1:0];
  assign busy     = (r_state != S_IDLE);
  assign err      = (r_state == S_CHK) && (mem_rdata != c_cfg);
  assign mm_rst_n = rst & r_mm_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_mats     <= '0;
      r_result   <= '0;
      r_mm_rst_n <= 1'b1;
      done       <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      mm_start   <= 1'b0;
      mm_show    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state  <= S_RD_CFG;
            mem_rd   <= 1'b1;
            mem_addr <= '0;
          end
        end
        S_RD_CFG: begin
          mem_rd  <= 1'b0;
          r_state <= S_CHK;
        end
        S_CHK: begin
          if (mem_rdata == c_cfg) begin
            r_state  <= S_RD_MAT;
            mem_rd   <= 1'b1;
            mem_addr <= ADDR_W'(2);
            r_idx    <= '0;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RD_MAT: begin
          // r_idx counts RD_MAT cycles; data for read r_idx-1 is on mem_rdata now.
          if (r_idx != '0) begin
            r_mats <= {r_mats[(c_nrd-1)*WIDTH-1:0], w_rd_word};
          end
          if ((r_idx + ADDR_W'(1)) < c_rd_last) begin
            mem_addr <= r_idx + ADDR_W'(3);
          end else begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
          end
          if (r_idx == c_rd_last) begin
            r_state    <= S_CLR;
            r_mm_rst_n <= 1'b0;
          end
          r_idx <= r_idx + ADDR_W'(1);
        end
        S_CLR: begin
          r_mm_rst_n <= 1'b1;
          mm_start   <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          r_state <= S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          if (mm_finish) begin
            mm_start <= 1'b0;
            r_result <= mm_result;
            mm_show  <= 1'b1;
            r_state  <= S_SHOW;
          end
        end
        S_SHOW: begin
          mm_show   <= 1'b0;
          mem_wr    <= 1'b1;
          mem_addr  <= c_res_base;
          mem_wdata <= w_res_top;
          r_result  <= r_result << WIDTH;
          r_idx     <= '0;
          r_state   <= S_WR_RES;
        end
        S_WR_RES: begin
          if (r_idx == c_wr_last) begin
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= w_res_top;
            r_result  <= r_result << WIDTH;
            r_idx     <= r_idx + ADDR_W'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
// Directed bench for matrix_loader with a 1-cycle memory and a
// fixed-latency multiplier model whose finish flag is sticky.
module tb_matrix_loader;

  localparam int LAT = 3;

  logic         clk;
  logic         rst;
  logic         go;
  logic         busy;
  logic         done;
  logic         err;
  logic [4:0]   mem_addr;
  logic         mem_rd;
  logic [31:0]  mem_rdata;
  logic         mem_wr;
  logic [31:0]  mem_wdata;
  logic         mm_rst_n;
  logic         mm_start;
  logic         mm_show;
  logic         mm_finish;
  logic [127:0] mm_mat1;
  logic [127:0] mm_mat2;
  logic [127:0] mm_result;

  logic [31:0]  mem [0:31];
  logic [127:0] mm_res;
  logic [3:0]   mm_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_clr  = 0;
  int n_start = 0;
  int n_done = 0;
  int n_err  = 0;
  logic [36:0] wr_q[$];
  int rd_addr_q[$];
  int rd_cyc_q[$];

  localparam logic [127:0] RES_ID  = {32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  localparam logic [127:0] RES_B2B = {32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};
  localparam logic [127:0] EXP_M1  = {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};

  matrix_loader #(.R1(2), .C1(2), .C2(2), .WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mm_rst_n(mm_rst_n),
    .mm_start(mm_start), .mm_show(mm_show), .mm_finish(mm_finish),
    .mm_mat1(mm_mat1), .mm_mat2(mm_mat2), .mm_result(mm_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  initial mm_result = '0;
  always @(posedge clk) begin
    if (!mm_rst_n) begin
      mm_finish <= 1'b0;
      mm_cnt    <= '0;
    end else if (mm_start && !mm_finish) begin
      if (mm_cnt == 4'(LAT - 1)) begin
        mm_finish <= 1'b1;
        mm_result <= mm_res;
      end
      mm_cnt <= mm_cnt + 4'd1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (!mm_rst_n) n_clr++;
      if (mm_start)  n_start++;
      if (done)      n_done++;
      if (err)       n_err++;
      if (mem_rd) begin
        rd_addr_q.push_back(int'(mem_addr));
        rd_cyc_q.push_back(cyc);
      end
      if (mem_wr) wr_q.push_back({mem_addr, mem_wdata});
    end
    cyc++;
  end

  task automatic pulse_go;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst = 1'b0;
    go  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, mem_rd, mem_wr, mm_start, mm_show} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000", {busy, done, err, mem_rd, mem_wr, mm_start, mm_show});
    end
    checks++;
    if (mm_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_mm_rst_n got %b want 0", mm_rst_n);
    end
    checks++;
    if (mem_addr !== 5'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem got addr %h data %h want 0 0", mem_addr, mem_wdata);
    end
    checks++;
    if (mm_mat1 !== '0 || mm_mat2 !== '0) begin
      errors++;
      $display("FAIL reset_mats got %h %h want 0", mm_mat1, mm_mat2);
    end
    @(negedge clk);
    rst = 1'b1;
    go  = 1'b1;
    #1;
    checks++;
    if (mm_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_mm_rst_n got %b want 1", mm_rst_n);
    end
    @(posedge clk); #1;
    go = 1'b0;
    checks++;
    if ({busy, mem_rd} !== 2'b11 || mem_addr !== 5'd0) begin
      errors++;
      $display("FAIL first_go got busy/rd %b addr %0d want 11 0", {busy, mem_rd}, mem_addr);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL first_run_timeout got no done want done");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity;
    bit ok;
    logic [31:0] exp [4];
    int wb = wr_q.size();
    int cb = n_clr;
    int db = n_done;
    int eb = n_err;
    exp[0] = 32'h40000000; exp[1] = 32'h40400000;
    exp[2] = 32'h40800000; exp[3] = 32'h40A00000;
    pulse_go();
    wait_done(ok);
    @(posedge clk); #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL identity_timeout got no done want done");
    end
    checks++;
    if (n_clr - cb != 1) begin
      errors++;
      $display("FAIL identity_clr_pulses got %0d want 1", n_clr - cb);
    end
    checks++;
    if (n_done - db != 1 || n_err - eb != 0) begin
      errors++;
      $display("FAIL identity_done_err got done %0d err %0d want 1 0", n_done - db, n_err - eb);
    end
    checks++;
    if (wr_q.size() - wb != 4) begin
      errors++;
      $display("FAIL identity_wr_count got %0d want 4", wr_q.size() - wb);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb + i >= wr_q.size() || wr_q[wb+i] !== {5'(10 + i), exp[i]}) begin
        errors++;
        $display("FAIL identity_wr%0d got %h want %h", i,
                 (wb + i < wr_q.size()) ? wr_q[wb+i] : 37'h0, {5'(10 + i), exp[i]});
      end
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL identity_end got done %b busy %b want 0 0", done, busy);
    end
  endtask

  task automatic test_read_timing;
    bit ok;
    int rb = rd_addr_q.size();
    int exp_addr;
    pulse_go();
    wait_done(ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || rd_addr_q.size() - rb != 9) begin
      errors++;
      $display("FAIL read_count got %0d reads done %b want 9 1", rd_addr_q.size() - rb, ok);
    end
    for (int i = 0; i < 9; i++) begin
      exp_addr = (i == 0) ? 0 : i + 1;
      checks++;
      if (rb + i >= rd_addr_q.size() || rd_addr_q[rb+i] != exp_addr ||
          rd_cyc_q[rb+i] - rd_cyc_q[rb] != exp_addr) begin
        errors++;
        $display("FAIL read_seq%0d got addr %0d offset %0d want %0d %0d", i,
                 (rb + i < rd_addr_q.size()) ? rd_addr_q[rb+i] : -1,
                 (rb + i < rd_cyc_q.size()) ? rd_cyc_q[rb+i] - rd_cyc_q[rb] : -1,
                 exp_addr, exp_addr);
      end
    end
    checks++;
    if (mm_mat1 !== EXP_M1) begin
      errors++;
      $display("FAIL read_mat1 got %h want %h", mm_mat1, EXP_M1);
    end
    checks++;
    if (mm_mat2 !== RES_ID) begin
      errors++;
      $display("FAIL read_mat2 got %h want %h", mm_mat2, RES_ID);
    end
  endtask

  task automatic test_mismatch;
    int sb = n_start;
    int wb = wr_q.size();
    int eb = n_err;
    mem[0] = 32'h02020302;
    pulse_go();
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_err got err %b busy %b want 1 1", err, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_idle got err %b busy %b want 0 0", err, busy);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_start - sb != 0 || wr_q.size() - wb != 0 || n_err - eb != 1) begin
      errors++;
      $display("FAIL mismatch_side got starts %0d writes %0d errs %0d want 0 0 1",
               n_start - sb, wr_q.size() - wb, n_err - eb);
    end
    mem[0] = 32'h02020202;
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [31:0] exp [4];
    int wb = wr_q.size();
    int cb = n_clr;
    int sb = n_start;
    exp[0] = 32'h41000000; exp[1] = 32'h41100000;
    exp[2] = 32'h41200000; exp[3] = 32'h41300000;
    checks++;
    if (mm_finish !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stale_finish got %b want 1", mm_finish);
    end
    mm_res = RES_B2B;
    pulse_go();
    wait_done(ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || n_clr - cb != 1) begin
      errors++;
      $display("FAIL b2b_clr got pulses %0d done %b want 1 1", n_clr - cb, ok);
    end
    checks++;
    if (n_start - sb != LAT + 1) begin
      errors++;
      $display("FAIL b2b_start_len got %0d want %0d", n_start - sb, LAT + 1);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb + i >= wr_q.size() || wr_q[wb+i] !== {5'(10 + i), exp[i]}) begin
        errors++;
        $display("FAIL b2b_wr%0d got %h want %h", i,
                 (wb + i < wr_q.size()) ? wr_q[wb+i] : 37'h0, {5'(10 + i), exp[i]});
      end
    end
  endtask

  task automatic test_reset_midrun;
    bit ok;
    bit seen;
    logic [31:0] exp [4];
    int wb = wr_q.size();
    int db = n_done;
    exp[0] = 32'h40000000; exp[1] = 32'h40400000;
    exp[2] = 32'h40800000; exp[3] = 32'h40A00000;
    mm_res = RES_ID;
    seen = 1'b0;
    pulse_go();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mm_start) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midrun_start_timeout got no mm_start want mm_start");
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, mem_rd, mem_wr, mm_start, mm_show, mm_rst_n} !== 8'b0) begin
      errors++;
      $display("FAIL midrun_ctrl got %b want 00000000",
               {busy, done, err, mem_rd, mem_wr, mm_start, mm_show, mm_rst_n});
    end
    checks++;
    if (mem_addr !== 5'd0 || mem_wdata !== 32'd0 || mm_mat1 !== '0 || mm_mat2 !== '0) begin
      errors++;
      $display("FAIL midrun_data got addr %h wdata %h mat1 %h mat2 %h want 0",
               mem_addr, mem_wdata, mm_mat1, mm_mat2);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wr_q.size() - wb != 0 || n_done - db != 0) begin
      errors++;
      $display("FAIL midrun_aborted got writes %0d dones %0d want 0 0", wr_q.size() - wb, n_done - db);
    end
    pulse_go();
    wait_done(ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || n_done - db != 1) begin
      errors++;
      $display("FAIL midrun_rerun got dones %0d want 1", n_done - db);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb + i >= wr_q.size() || wr_q[wb+i] !== {5'(10 + i), exp[i]}) begin
        errors++;
        $display("FAIL midrun_wr%0d got %h want %h", i,
                 (wb + i < wr_q.size()) ? wr_q[wb+i] : 37'h0, {5'(10 + i), exp[i]});
      end
    end
  endtask

  task automatic test_go_held;
    bit ok;
    go = 1'b1;
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL held_first_timeout got no done want done");
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL held_idle got busy %b rd %b want 0 0", busy, mem_rd);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 5'd0) begin
      errors++;
      $display("FAIL held_restart got busy %b rd %b addr %0d want 1 1 0", busy, mem_rd, mem_addr);
    end
    go = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL held_second_timeout got no done want done");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    go  = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0] = 32'h02020202;
    mem[2] = 32'h3F800000; mem[3] = 32'h00000000;
    mem[4] = 32'h00000000; mem[5] = 32'h3F800000;
    mem[6] = 32'h40000000; mem[7] = 32'h40400000;
    mem[8] = 32'h40800000; mem[9] = 32'h40A00000;
    mm_res = RES_ID;

    test_reset();
    test_identity();
    test_read_timing();
    test_mismatch();
    test_back_to_back();
    test_reset_midrun();
    test_go_held();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
